uart_rx_port: RTL
=================

# uart_rx_port

Receive-side UART peripheral for the retro CPU system. Captures bytes delivered by the rs232c receiver (RX_DATA/RX_DATA_EN), buffers them in a small register FIFO and exposes them to the CPU as two memory-mapped read locations: a data port that pops one byte per read and a status port. Sits between the rs232c RX outputs and the CPU data_in mux, alongside the program ROM.

## Interface
- ADDRESS_WIDTH, 16, CPU address bus width
- ADR_WIDTH, 4, log2 of FIFO depth (default 16 bytes)
- DATA_ADDR, 16'hFFFE, data port address (read pops)
- STAT_ADDR, 16'hFFFD, status port address

- CLK  input  1  system clock, all state on rising edge
- RESET_N  input  1  asynchronous active-low reset
- RX_DATA  input  8  received byte from rs232c
- RX_DATA_EN  input  1  one-cycle strobe, RX_DATA valid
- ADDRESS  input  ADDRESS_WIDTH  CPU address
- RDEN  input  1  CPU read strobe, qualifies side effects of ADDRESS
- RDATA  output  8  read data (combinational from ADDRESS and state)
- RSEL  output  1  high when ADDRESS equals DATA_ADDR or STAT_ADDR; top level selects RDATA over ROM data
- RX_READY  output  1  FIFO not empty
- OVERRUN  output  1  sticky: byte dropped because FIFO full
- COUNT  output  ADR_WIDTH+1  bytes currently buffered, 0..2^ADR_WIDTH

## Operation
- Storage: 2^ADR_WIDTH x 8 register array, not reset. Write/read pointers ADR_WIDTH+1 bits; low ADR_WIDTH bits index, MSB distinguishes full from empty; both wrap modulo 2^(ADR_WIDTH+1).
- empty = (wptr == rptr); full = index bits equal and MSBs differ. COUNT = wptr - rptr (ADR_WIDTH+1 bit modular subtraction).
- Push: RX_DATA_EN and (not full, or pop in same cycle) -> store RX_DATA at wptr, wptr+1.
- Drop: RX_DATA_EN, full and no pop in same cycle -> byte discarded, pointers unchanged, OVERRUN set.
- Pop: RDEN and ADDRESS == DATA_ADDR and not empty -> rptr+1. Read of empty data port: RDATA = 8'h00, no pointer change, no flag change.
- RDATA mux: ADDRESS == DATA_ADDR -> mem[rptr] if not empty else 8'h00; ADDRESS == STAT_ADDR -> {5'b0, OVERRUN, full, ~empty}; otherwise 8'h00. RSEL independent of RDEN.
- Status read clear: RDEN and ADDRESS == STAT_ADDR clears OVERRUN at the edge; a drop in the same cycle wins (OVERRUN stays 1).
- Simultaneous push and pop: full -> both performed, COUNT unchanged, no overrun; empty -> only push performed (pop gated by empty), COUNT becomes 1.
- RX_READY = ~empty, registered-state derived (no combinational path from RX_DATA_EN).

## Timing
- Reset (asynchronous assert, synchronous-to-CLK release by top): wptr = rptr = 0, OVERRUN = 0; hence RX_READY = 0, COUNT = 0, RDATA = 8'h00 for any address. Buffered bytes are lost on reset mid-operation; in-flight RX_DATA_EN during reset ignored.
- Push latency: byte strobed at edge N is readable on RDATA and reflected in RX_READY/COUNT from edge N+1.
- Pop: RDATA shows head combinationally in the cycle RDEN is high; next byte (or 8'h00 if now empty) visible after that edge. CPU must sample RDATA in the same cycle it asserts RDEN.
- Back-to-back pops on consecutive cycles allowed, one byte per cycle. Back-to-back pushes on consecutive cycles allowed.
- OVERRUN rises the cycle after the dropping edge; stays until a status read or reset.

## Test plan
- Reset: assert RESET_N=0 mid-stream with COUNT=5 -> COUNT=0, RX_READY=0, OVERRUN=0 immediately; status read returns 8'h00.
- Single byte: strobe RX_DATA=8'h41 -> next cycle RX_READY=1, COUNT=1, status=8'h01; read DATA_ADDR with RDEN -> RDATA=8'h41, then COUNT=0, data read returns 8'h00.
- Fill and order: push 8'h00..8'h0F -> status=8'h03, COUNT=16; 16 pops return 8'h00..8'h0F in order; then pushes 8'h10..8'h17 and pops verify pointer wrap.
- Overrun: with FIFO full push 8'hAA -> dropped, status=8'h07, head unchanged; status read clears OVERRUN (status next=8'h03); repeat with drop coincident with status read -> OVERRUN remains 1.
- Simultaneous push/pop: full FIFO, push 8'h55 with pop same cycle -> no overrun, COUNT=16, 8'h55 is last byte popped; empty FIFO, push 8'h66 with pop -> RDATA=8'h00 that cycle, COUNT=1 after.
- Decode: RDEN on address 16'h00FF and 16'hFFFF -> RSEL=0, RDATA=8'h00, no pointer or flag change.

Source files
------------

// File: rtl/uart_rx_port.sv
// Receive-side UART port: buffers bytes from the rs232c receiver in a register FIFO
// and exposes them to the CPU as a popping data port and a status port.
module uart_rx_port #(
  parameter int                     ADDRESS_WIDTH = 16,
  parameter int                     ADR_WIDTH     = 4,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDR   = 16'hFFFE,
  parameter logic [ADDRESS_WIDTH-1:0] STAT_ADDR   = 16'hFFFD
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_DATA_EN,
  input  logic [ADDRESS_WIDTH-1:0] ADDRESS,
  input  logic                     RDEN,
  output logic [7:0]               RDATA,
  output logic                     RSEL,
  output logic                     RX_READY,
  output logic                     OVERRUN,
  output logic [ADR_WIDTH:0]       COUNT
);

  localparam int DEPTH = 1 << ADR_WIDTH;

  // Handshake: RX_DATA_EN is a one-cycle strobe with no back-pressure; a byte that
  // finds the FIFO full (and no pop that cycle) is dropped and flagged in OVERRUN.
  // A CPU pop is RDEN with ADDRESS == DATA_ADDR; RDATA must be sampled that cycle.
  logic [7:0]         mem [DEPTH];
  logic [ADR_WIDTH:0] wptr;
  logic [ADR_WIDTH:0] rptr;
  logic               empty;
  logic               full;
  logic               data_sel;
  logic               stat_sel;
  logic               pop;
  logic               push;
  logic               drop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[ADR_WIDTH-1:0] == rptr[ADR_WIDTH-1:0]) &&
                    (wptr[ADR_WIDTH] != rptr[ADR_WIDTH]);
  assign data_sel = (ADDRESS == DATA_ADDR);
  assign stat_sel = (ADDRESS == STAT_ADDR);
  assign pop      = RDEN && data_sel && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a byte.
  assign push     = RX_DATA_EN && (!full || pop);
  assign drop     = RX_DATA_EN && full && !pop;

  assign RSEL     = data_sel || stat_sel;
  assign RX_READY = !empty;
  assign COUNT    = wptr - rptr;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr[ADR_WIDTH-1:0]] <= RX_DATA;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr    <= '0;
      rptr    <= '0;
      OVERRUN <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (ADR_WIDTH+1)'(1);
      if (pop)  rptr <= rptr + (ADR_WIDTH+1)'(1);
      // A drop coinciding with a status read keeps the flag set.
      if (drop)                      OVERRUN <= 1'b1;
      else if (RDEN && stat_sel)     OVERRUN <= 1'b0;
    end
  end

  always_comb begin
    RDATA = 8'h00;
    if (data_sel) begin
      if (!empty) RDATA = mem[rptr[ADR_WIDTH-1:0]];
    end else if (stat_sel) begin
      RDATA = {5'b0, OVERRUN, full, !empty};
    end
  end

endmodule
